// File: rtl/z3_sched_if.sv
// Bus bundle for the z3 output-layer scheduler: run control, activations,
// weight-memory read port and the result handshake.
interface z3_sched_if #(
    parameter int AW = 6
);
    logic               start;
    logic signed [31:0] a2_1;
    logic signed [31:0] a2_2;
    logic signed [31:0] a2_3;
    logic               w_rd;
    logic [AW-1:0]      w_addr;
    logic signed [31:0] w_data;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         z3;
    logic [3:0]         out_idx;
    logic               done;

    // Environment side: issues runs, serves weight reads, consumes results.
    modport master (
        output start, a2_1, a2_2, a2_3, w_data, out_ready,
        input  w_rd, w_addr, busy, out_valid, z3, out_idx, done
    );

    // Scheduler side.
    modport slave (
        input  start, a2_1, a2_2, a2_3, w_data, out_ready,
        output w_rd, w_addr, busy, out_valid, z3, out_idx, done
    );
endinterface

// File: rtl/z3_sched.sv
// Output-layer neuron scheduler: for each of N_OUT neurons fetch bias and
// three weights, accumulate bias + sum(a2_k * w3_k) in Q.24, saturate to
// Q4.4 and present the result on a valid/ready handshake.
module z3_sched #(
    parameter int N_OUT = 2,
    parameter int AW    = 6
) (
    input  logic       clk,
    input  logic       reset,
    z3_sched_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_OUTPUT,
        S_DONE
    } state_t;

    localparam logic [3:0] N_LAST = 4'(N_OUT - 1);

    // +/-8.0 in Q.24, the Q4.4 representable range limits.
    localparam logic signed [39:0] SAT_HI = 40'sh00_0800_0000;
    localparam logic signed [39:0] SAT_LO = -40'sh00_0800_0000;

    state_t             state_q, state_d;
    logic [1:0]         k_q, k_d;
    logic [3:0]         n_q, n_d;
    logic signed [31:0] a2_1_q, a2_1_d;
    logic signed [31:0] a2_2_q, a2_2_d;
    logic signed [31:0] a2_3_q, a2_3_d;
    logic               rd_vld_q, rd_vld_d;
    logic [1:0]         rd_k_q, rd_k_d;
    logic signed [39:0] acc_q, acc_d;
    logic [7:0]         z3_q, z3_d;

    logic signed [31:0] a2_sel;
    logic signed [63:0] prod;
    logic signed [39:0] prod_sh;
    logic [23:0]        prod_frac_unused;

    // Q.24 accumulator to Q4.4 with clamping outside [-8.0, 8.0).
    function automatic logic [7:0] sat_q44(input logic signed [39:0] a);
        if (a >= SAT_HI)
            return 8'h7F;
        else if (a < SAT_LO)
            return 8'h80;
        else
            return a[27:20];
    endfunction

    // Full-width signed product; dropping the low 24 bits is an arithmetic
    // shift right by 24 (floor), and the kept 40 bits cannot overflow.
    always_comb begin
        case (rd_k_q)
            2'd1:    a2_sel = a2_1_q;
            2'd2:    a2_sel = a2_2_q;
            default: a2_sel = a2_3_q;
        endcase
        prod = a2_sel * bus.w_data;
        {prod_sh, prod_frac_unused} = prod;
    end

    // Next-state, datapath updates and result capture.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        n_d      = n_q;
        a2_1_d   = a2_1_q;
        a2_2_d   = a2_2_q;
        a2_3_d   = a2_3_q;
        z3_d     = z3_q;
        acc_d    = acc_q;
        // Read data returns one cycle after the strobe; track which term it is.
        rd_vld_d = (state_q == S_FETCH);
        rd_k_d   = k_q;

        if (rd_vld_q) begin
            if (rd_k_q == 2'd0)
                acc_d = 40'(bus.w_data);
            else
                acc_d = acc_q + prod_sh;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a2_1_d  = bus.a2_1;
                    a2_2_d  = bus.a2_2;
                    a2_3_d  = bus.a2_3;
                    n_d     = 4'd0;
                    k_d     = 2'd0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Last weight term lands this cycle; capture the final result.
                z3_d    = sat_q44(acc_d);
                state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (bus.out_ready) begin
                    if (n_q == N_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        n_d     = n_q + 4'd1;
                        k_d     = 2'd0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over any start request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            k_q      <= 2'd0;
            n_q      <= 4'd0;
            a2_1_q   <= '0;
            a2_2_q   <= '0;
            a2_3_q   <= '0;
            rd_vld_q <= 1'b0;
            rd_k_q   <= 2'd0;
            acc_q    <= '0;
            z3_q     <= 8'h00;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            n_q      <= n_d;
            a2_1_q   <= a2_1_d;
            a2_2_q   <= a2_2_d;
            a2_3_q   <= a2_3_d;
            rd_vld_q <= rd_vld_d;
            rd_k_q   <= rd_k_d;
            acc_q    <= acc_d;
            z3_q     <= z3_d;
        end
    end

    // Outputs decoded from state so they are glitch-free relative to the FSM.
    always_comb begin
        bus.w_rd      = (state_q == S_FETCH);
        bus.w_addr    = (state_q == S_FETCH) ? AW'({n_q, k_q}) : '0;
        bus.busy      = (state_q == S_FETCH) || (state_q == S_DRAIN) ||
                        (state_q == S_OUTPUT);
        bus.out_valid = (state_q == S_OUTPUT);
        bus.z3        = z3_q;
        bus.out_idx   = n_q;
        bus.done      = (state_q == S_DONE);
    end
endmodule
